qspi_mem_slave: RTL

//  Parametrised SPI/dual/quad flash-style slave memory for QSPI master benches and SoC sims.

---
 rtl/qspi_mem_slave_if.sv | 22 ++
 rtl/qspi_mem_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_mem_slave_if.sv
// Pad-side QSPI bundle between a QSPI master model and the flash-style slave memory.
// Holds the lanes, the chip select, the runtime lane/dummy configuration and the device status outputs.
interface qspi_mem_slave_if;
  logic       spi_csn;
  logic [3:0] spi_sdi;
  logic [3:0] spi_sdo;
  logic [3:0] spi_oe;
  logic [1:0] cfg_lanes;
  logic [7:0] cfg_rd_dummy;
  logic       wel;
  logic       cmd_err;

  modport slave (
    input  spi_csn, spi_sdi, cfg_lanes, cfg_rd_dummy,
    output spi_sdo, spi_oe, wel, cmd_err
  );

  modport master (
    output spi_csn, spi_sdi, cfg_lanes, cfg_rd_dummy,
    input  spi_sdo, spi_oe, wel, cmd_err
  );
endinterface

// File: rtl/qspi_mem_slave.sv
// SPI/dual/quad flash-style slave memory: WREN/WRDI/READ/PP, read dummy cycles and wrapping streams.
// Defining QSPI_STATUS_EN adds the RDSR (0x05) status-byte stream.
module qspi_mem_slave #(
  parameter int CMD_W     = 8,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 64,
  parameter int DATA_W    = 32
) (
  input  logic            spi_clk,
  input  logic            spi_rst,
  qspi_mem_slave_if.slave bus
);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int SH_W    = (CMD_W > ADDR_W) ? ((CMD_W > DATA_W) ? CMD_W : DATA_W)
                                            : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
  localparam int CNT_MAX = (SH_W > 255) ? SH_W : 255;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CMD_LEN  = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] ADDR_LEN = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] STAT_LEN = CNT_W'(8);

  localparam logic [CMD_W-1:0] OP_WREN = CMD_W'(8'h06);
  localparam logic [CMD_W-1:0] OP_WRDI = CMD_W'(8'h04);
  localparam logic [CMD_W-1:0] OP_READ = CMD_W'(8'h03);
  localparam logic [CMD_W-1:0] OP_PP   = CMD_W'(8'h02);
`ifdef QSPI_STATUS_EN
  localparam logic [CMD_W-1:0] OP_RDSR = CMD_W'(8'h05);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nx, dcnt;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc, addr_idx;
  logic               is_rd_q, is_rd_d, pp_q, pp_d, stat_q, stat_d;
  logic               wel_q, wel_d, err_q, err_d;
  logic [3:0]         sdo_q, sdo_d, oe_q, oe_d;
  logic [SH_W-1:0]    rx_q, rx_d, rx_nx;
  logic [DATA_W-1:0]  tx_q, tx_d, mem_wdata;
  logic               mem_we;
  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  function automatic logic [2:0] lane_n(input logic [1:0] l);
    case (l)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] l);
    case (l)
      2'b00:   return 4'b0010;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [SH_W-1:0] shift_in(input logic [SH_W-1:0] sh, input logic [3:0] d,
                                               input logic [1:0] l);
    case (l)
      2'b00:   return {sh[SH_W-2:0], d[0]};
      2'b01:   return {sh[SH_W-3:0], d[1:0]};
      default: return {sh[SH_W-5:0], d};
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] t, input logic [1:0] l);
    case (l)
      2'b00:   return {t[DATA_W-2:0], 1'b0};
      2'b01:   return {t[DATA_W-3:0], 2'b00};
      default: return {t[DATA_W-5:0], 4'b0000};
    endcase
  endfunction

  // Single lane drives on IO1; wider modes put the higher bit on the higher lane.
  function automatic logic [3:0] top_bits(input logic [DATA_W-1:0] t, input logic [1:0] l);
    case (l)
      2'b00:   return {2'b00, t[DATA_W-1], 1'b0};
      2'b01:   return {2'b00, t[DATA_W-1 -: 2]};
      default: return t[DATA_W-1 -: 4];
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] status_word(input logic w);
    logic [DATA_W-1:0] r;
    r = '0;
    r[DATA_W-1 -: 8] = {6'b0, w, 1'b0};
    return r;
  endfunction

  assign rx_nx    = shift_in(rx_q, bus.spi_sdi, bus.cfg_lanes);
  assign cnt_nx   = cnt_q + CNT_W'(lane_n(bus.cfg_lanes));
  assign dcnt     = cnt_q + 1'b1;
  assign idx_inc  = idx_q + 1'b1;
  assign addr_idx = rx_nx[2 +: IDX_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    is_rd_d   = is_rd_q;
    pp_d      = pp_q;
    stat_d    = stat_q;
    wel_d     = wel_q;
    err_d     = 1'b0;
    sdo_d     = '0;
    oe_d      = '0;
    rx_d      = rx_q;
    tx_d      = tx_q;
    mem_we    = 1'b0;
    mem_wdata = rx_nx[DATA_W-1:0];
    // Deselect wins over any lane data sampled on the same edge, so a late last bit is dropped.
    if (bus.spi_csn) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      stat_d  = 1'b0;
      if (pp_q) begin
        wel_d = 1'b0;
        pp_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_CMD: begin
          rx_d    = rx_nx;
          cnt_d   = cnt_nx;
          state_d = S_CMD;
          if (cnt_nx >= CMD_LEN) begin
            cnt_d   = '0;
            state_d = S_HOLD;
            case (rx_nx[CMD_W-1:0])
              OP_WREN: wel_d = 1'b1;
              OP_WRDI: wel_d = 1'b0;
              OP_READ: begin state_d = S_ADDR; is_rd_d = 1'b1; end
              OP_PP:   begin state_d = S_ADDR; is_rd_d = 1'b0; pp_d = 1'b1; end
`ifdef QSPI_STATUS_EN
              OP_RDSR: begin state_d = S_RDATA; stat_d = 1'b1; tx_d = status_word(wel_q); end
`endif
              default: err_d = 1'b1;
            endcase
          end
        end
        S_ADDR: begin
          rx_d  = rx_nx;
          cnt_d = cnt_nx;
          if (cnt_nx >= ADDR_LEN) begin
            cnt_d = '0;
            idx_d = addr_idx;
            if (!is_rd_q) begin
              state_d = S_WDATA;
            end else if (bus.cfg_rd_dummy != 8'd0) begin
              state_d = S_DUMMY;
            end else begin
              state_d = S_RDATA;
              tx_d    = mem[addr_idx];
            end
          end
        end
        S_DUMMY: begin
          cnt_d = dcnt;
          if (dcnt >= CNT_W'(bus.cfg_rd_dummy)) begin
            cnt_d   = '0;
            state_d = S_RDATA;
            tx_d    = mem[idx_q];
          end
        end
        S_RDATA: begin
          sdo_d = top_bits(tx_q, bus.cfg_lanes);
          oe_d  = lane_mask(bus.cfg_lanes);
          tx_d  = shift_out(tx_q, bus.cfg_lanes);
          cnt_d = cnt_nx;
          // The last slice of a word goes out on the same edge the next word is loaded.
          if (cnt_nx >= (stat_q ? STAT_LEN : DATA_LEN)) begin
            cnt_d = '0;
            if (stat_q) begin
              tx_d = status_word(wel_q);
            end else begin
              idx_d = idx_inc;
              tx_d  = mem[idx_inc];
            end
          end
        end
        S_WDATA: begin
          rx_d  = rx_nx;
          cnt_d = cnt_nx;
          if (cnt_nx >= DATA_LEN) begin
            cnt_d  = '0;
            mem_we = wel_q;
            idx_d  = idx_inc;
          end
        end
        S_HOLD: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      is_rd_q <= 1'b0;
      pp_q    <= 1'b0;
      stat_q  <= 1'b0;
      wel_q   <= 1'b0;
      err_q   <= 1'b0;
      sdo_q   <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      is_rd_q <= is_rd_d;
      pp_q    <= pp_d;
      stat_q  <= stat_d;
      wel_q   <= wel_d;
      err_q   <= err_d;
      sdo_q   <= sdo_d;
      oe_q    <= oe_d;
    end
  end

  // Shift registers carry no state of their own once the FSM is back in IDLE.
  always_ff @(posedge spi_clk) begin
    rx_q <= rx_d;
    tx_q <= tx_d;
  end

  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[idx_q] <= mem_wdata;
    end
  end

  assign bus.spi_sdo = sdo_q;
  assign bus.spi_oe  = oe_q;
  assign bus.wel     = wel_q;
  assign bus.cmd_err = err_q;
endmodule
